// File: rtl/sipo_rx_pkg.sv
// Shared serial framing definitions: frame layout, line levels and receiver states.
package sipo_rx_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_START = 2'd1;
  localparam rx_state_t ST_DATA  = 2'd2;
  localparam rx_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/sipo_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // capture chain; both stages reset to the idle level of the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= RESET_VAL;
      q_r    <= RESET_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sipo_rx.sv
// Oversampled 8N1 serial receiver: start-bit qualification, mid-bit sampling,
// single-character holding register with overrun and framing-error reporting.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       serial_in,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic          line_s;
  rx_state_t     state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    shreg_r, shreg_s;
  logic          stop_sample_s;
  logic          good_s;
  logic          bad_s;
  logic          load_s;

  logic [7:0]    data_r;
  logic          valid_r;
  logic          fe_r;
  logic          ovr_r;
  logic          busy_r;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (line_s)
  );

  // framing FSM: next state, tick counter, bit index and shift register
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    idx_s         = idx_r;
    shreg_s       = shreg_r;
    stop_sample_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sample_tick && (line_s == START_BIT)) begin
          state_s = ST_START;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_tick && (cnt_r == HALF_LAST)) begin
          cnt_s = '0;
          idx_s = 3'd0;
          if (line_s == START_BIT) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (sample_tick) begin
          cnt_s = cnt_r + 1'b1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_DATA: begin
        if (sample_tick && (cnt_r == FULL_LAST)) begin
          cnt_s   = '0;
          shreg_s = {shreg_r[6:0], line_s};
          if (idx_r == IDX_LAST) begin
            state_s = ST_STOP;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end else if (sample_tick) begin
          cnt_s = cnt_r + 1'b1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_STOP: begin
        if (sample_tick && (cnt_r == FULL_LAST)) begin
          stop_sample_s = 1'b1;
          cnt_s         = '0;
          state_s       = ST_IDLE;
        end else if (sample_tick) begin
          cnt_s = cnt_r + 1'b1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        idx_s   = 3'd0;
      end
    endcase
  end

  // a new character is only accepted when the holding register is free or being freed now
  always_comb begin
    good_s = stop_sample_s && (line_s == STOP_BIT);
    bad_s  = stop_sample_s && (line_s != STOP_BIT);
    load_s = good_s && (!valid_r || rx_ack);
  end

  // FSM and datapath state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shreg_r <= 8'h00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shreg_r <= shreg_s;
    end
  end

  // registered consumer-facing outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      fe_r    <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      fe_r   <= bad_s;
      busy_r <= (state_s != ST_IDLE);
      if (load_s) begin
        data_r  <= shreg_r;
        valid_r <= 1'b1;
      end else if (rx_ack) begin
        valid_r <= 1'b0;
      end
      if (rx_ack && valid_r) begin
        ovr_r <= 1'b0;
      end else if (good_s && valid_r) begin
        ovr_r <= 1'b1;
      end
    end
  end

  assign data_out  = data_r;
  assign rx_valid  = valid_r;
  assign frame_err = fe_r;
  assign overrun   = ovr_r;
  assign busy      = busy_r;

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, number of sample_tick pulses per serial bit period.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: sample_tick  input  1  one-clk-wide enable pulse at OVERSAMPLE x bit rate; the block ignores it while reset is asserted.
REQ-005 Port: serial_in  input  1  asynchronous serial line; idle high; frames arrive first-bit-first.
REQ-006 Port: rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-007 Port: data_out  output  8  last good received character, bit 7 = first data bit on the line.
REQ-008 Port: rx_valid  output  1  data_out holds an unacknowledged character.
REQ-009 Port: frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 Port: overrun  output  1  sticky: a good frame completed while rx_valid was high.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block shall receive 10-bit frames, sent first-bit-first: start bit (0), 8 data bits, stop bit (1).
REQ-013 The block shall pass serial_in through a 2-flop synchronizer; all decisions shall use the synchronized line (2-clk input latency).
REQ-014 FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE: on a sample_tick with the synchronized line 0 -> START, tick counter cleared to 0.
REQ-016 START: the counter increments on each sample_tick; at count OVERSAMPLE/2-1 the line is sampled: 0 -> DATA with counter and bit index cleared; 1 -> IDLE (false start, no output change).
REQ-017 DATA: each bit is sampled on the OVERSAMPLE-th tick after the previous sample and shifted in as shreg <= {shreg[6:0], bit}; after the 8th bit -> STOP.
REQ-018 STOP: the stop bit is sampled OVERSAMPLE ticks after the last data bit; 1 = good frame, 0 = framing error; either way -> IDLE in the same cycle.
REQ-019 Good frame with rx_valid low or rx_ack high in the same cycle: data_out <= shreg, rx_valid <= 1 on the next edge.
REQ-020 Good frame with rx_valid high and rx_ack low: data_out shall be kept, the new character dropped, overrun set.
REQ-021 Framing error: frame_err high for exactly one clk; data_out and rx_valid unchanged; overrun unchanged.
REQ-022 rx_ack with rx_valid high shall clear rx_valid and overrun on the next edge unless REQ-019 applies in the same cycle (rx_valid then stays 1, overrun cleared).
REQ-023 rx_ack with rx_valid low shall have no effect.
REQ-024 Counter widths shall be $clog2(OVERSAMPLE) bits for the tick counter and 3 bits for the bit index; no wrap outside the rules above.
REQ-025 A low serial_in during DATA or STOP shall not restart framing; start detection occurs only in IDLE.

Reset
REQ-026 While reset is low: state IDLE, synchronizer flops 1, counters 0, shreg 0, data_out 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 Reset mid-frame shall abort the frame with no output update; reception resumes at the next start bit after release.

Structure
REQ-028 The state enumeration, FRAME_BITS = 10, DATA_BITS = 8 and the start/stop bit values shall live in the shared serial package used by the transmitter.
REQ-029 The 2-flop synchronizer shall be a sub-module named sync2 (reset value 1); the FSM, counters and shift register stay in sipo_rx.

Verification
REQ-030 OVERSAMPLE = 16, tick every 4 clk, frame for 8'hA5 (0,1,0,1,0,0,1,0,1,1) -> data_out = 8'hA5 and rx_valid = 1 within 3 clk after the stop-bit sample; frame_err = 0.
REQ-031 Low glitch of 5 ticks in IDLE -> START then IDLE, busy pulses, no rx_valid, data_out unchanged.
REQ-032 Frame 8'h3C with the stop bit driven 0 -> one-clk frame_err, rx_valid stays 0, data_out stays 8'h00.
REQ-033 Frames 8'h11 then 8'h22 with no rx_ack -> data_out = 8'h11, overrun = 1; rx_ack -> rx_valid = 0, overrun = 0.
REQ-034 rx_ack asserted in the same cycle that frame 8'h7E completes while holding 8'h11 -> data_out = 8'h7E, rx_valid = 1, overrun = 0.
REQ-035 reset pulsed low during the 4th data bit of 8'hFF, then frame 8'h0F -> no output from the aborted frame; data_out = 8'h0F, rx_valid = 1.
